reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Per-register in-flight write tracker between the decode stage and `regfile`. Records every issued instruction that will write a general register, clears the record when that write reaches the `regfile` write port, and raises a stall request when a decoding instruction reads a register whose write has not yet retired. Its retire inputs connect to the same `we`/`waddr` nets that drive `regfile`. It therefore mirrors `regfile`'s write-through rule: a write retiring in the current cycle is not a hazard.

## Interface
Parameters:
- `REG_NUM`, 32: number of tracked registers; register 0 is never tracked.
- `CNT_W`, 2: width of each pending-write counter; the maximum is `2^CNT_W-1` (3) outstanding writes per register.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `issue_valid`  in  1: decode presents an instruction this cycle.
- `issue_we`  in  1: the instruction writes a general register.
- `issue_waddr`  in  5: destination register.
- `re1`, `raddr1`  in  1, 5: source 1 read enable and address.
- `re2`, `raddr2`  in  1, 5: source 2 read enable and address.
- `wb_we`, `wb_waddr`  in  1, 5: retiring write, the same nets as `regfile` `we`/`waddr`.
- `flush`  in  1: pipeline flush; discards all in-flight writes.
- `stall_req`  out  1: combinational; decode must hold the instruction.
- `issue_fire`  out  1: combinational; `issue_valid & ~stall_req & ~flush`. The entry is recorded on this cycle's edge.
- `busy`  out  `REG_NUM`: registered; bit n set when counter n is non-zero. Bit 0 is always 0.
- `err`  out  1: registered sticky flag; set when a retire arrives for a counter at 0. Cleared only by reset.

## Operation
- State: `cnt[n]`, a `CNT_W`-bit counter for n = 1..`REG_NUM`-1, plus `err`. There is no FSM beyond the counters.
- Effective pending count for a source: `cnt[a] - (wb_we && wb_waddr==a)`. A retire in the same cycle counts as already done, matching `regfile` bypass.
- Source hazard: `re_k && raddr_k!=0 && effective_cnt(raddr_k)!=0`.
- Destination overflow: `issue_we && issue_waddr!=0 && cnt[issue_waddr]==max`, with no same-cycle retire to that register.
- `stall_req = issue_valid & ~flush & (hazard1 | hazard2 | overflow)`.
- Per-register counter update, in priority order:
  - `flush` set: all counters go to 0. The retire and issue in that cycle are ignored.
  - Otherwise: `inc = issue_fire & issue_we & issue_waddr==n`, `dec = wb_we & wb_waddr==n & cnt[n]!=0`.
    - inc and dec both set: counter unchanged.
    - inc only: counter +1.
    - dec only: counter -1.
- Address 0 is ignored on every path. It never stalls, never counts, and never sets `err`.
- `wb_we` with `cnt[wb_waddr]==0` (and no flush): the counter stays 0 and `err` is set.
- An instruction whose destination equals one of its own sources, e.g. `addu $3,$3,$4`, stalls only on the older pending write. Its own increment happens at issue.

## Timing
- Reset (`rst`=0, asynchronous): all `cnt`=0, `busy`=0, `err`=0. `stall_req` is forced to 0 while reset is asserted. Deasserting reset mid-pipeline leaves an empty scoreboard.
- `stall_req` and `issue_fire` have zero latency: they are combinational from the inputs and the current counters.
- Issue at edge k sets `busy[n]` visible from cycle k+1.
- A retire in cycle k unblocks a dependent reader in the same cycle k. The counter drops at edge k.
- A flush in cycle k gives an empty scoreboard in cycle k+1. `stall_req`=0 during cycle k.
- Critical path: the 5-to-32 source decode, the counter mux, and the compare. Only `err` and the counters are registered outputs.

## Structure
- Shared package `defines.v` additions:
  - `` `ScbCntBus `` for the counter width.
  - `` `ScbMax `` for the saturation value.
  - Reuse `` `RegAddrBus `` and `` `RegNum ``.
  - The active-low reset levels `` `RstnEnable ``/`` `RstnDisable ``.
- One natural sub-module, `scb_cnt`: a single up/down counter with inc, dec, clr, and a zero flag. It is instantiated `REG_NUM`-1 times by generate.

## Test plan
- Reset, then issue `addu $5` (we=1, waddr=5). `busy[5]`=1 next cycle. Issue reader raddr1=5 → `stall_req`=1. Retire waddr=5 in that cycle → `stall_req`=0 in the same cycle, `busy[5]`=0 next cycle.
- Issue three writes to $7 in consecutive cycles → `cnt[7]`=3. A fourth issue to $7 → `stall_req`=1 and `issue_fire`=0. With a simultaneous retire of $7 → `issue_fire`=1 and cnt stays 3.
- Reader raddr1=0, re1=1, and issue waddr=0 → never stalls. `busy`=0 and `err` stays 0.
- Issue to $9 and $10, then `flush` with a concurrent retire of $9 → next cycle `busy`=0 and `err`=0.
- Retire waddr=12 with `busy[12]`=0 → `err`=1 next cycle, held until `rst`=0.
- Assert `rst` low mid-sequence with several registers busy → `busy`=0 and `err`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
//   Shared constants and helpers for the register write scoreboard.
//   SCB_CNT_W / SCB_MAX   : pending-write counter width and saturation value
//   SCB_ADDR_W / SCB_REG_NUM : register address width and register count
//   RSTN_ENABLE / RSTN_DISABLE : active-low reset levels
package reg_scoreboard_pkg;

  localparam int SCB_REG_NUM = 32;
  localparam int SCB_ADDR_W  = 5;
  localparam int SCB_CNT_W   = 2;
  localparam int SCB_MAX     = (1 << SCB_CNT_W) - 1;

  localparam logic RSTN_ENABLE  = 1'b0;
  localparam logic RSTN_DISABLE = 1'b1;

  // True when a write port targets register a; register 0 never matches.
  function automatic logic wr_hit(input logic                  we,
                                  input logic [SCB_ADDR_W-1:0] waddr,
                                  input logic [SCB_ADDR_W-1:0] a);
    return we && (waddr == a) && (a != '0);
  endfunction

endpackage

// File: rtl/reg_scoreboard_cnt.sv
// scb_cnt
//   One pending-write up/down counter.
//   clk, rst        : clock, async active-low reset
//   clr             : synchronous clear (highest priority)
//   inc, dec        : count up / down; both together hold the value
//   cnt             : current count
//   zero            : cnt == 0
module scb_cnt
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SCB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Tracks in-flight general-register writes between decode and regfile and
//   requests a decode stall on read-after-write or counter overflow.
//   clk, rst                : clock, async active-low reset
//   issue_valid/we/waddr    : instruction presented by decode
//   re1/raddr1, re2/raddr2  : source operand reads
//   wb_we/wb_waddr          : retiring write (same nets as regfile we/waddr)
//   flush                   : discard all in-flight writes
//   stall_req, issue_fire   : combinational handshake to decode
//   busy                    : per-register pending flag (bit 0 always 0)
//   err                     : sticky, retire seen for a register with no pending write
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int REG_NUM = SCB_REG_NUM,
  parameter int CNT_W   = SCB_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [SCB_ADDR_W-1:0] issue_waddr,
  input  logic                  re1,
  input  logic [SCB_ADDR_W-1:0] raddr1,
  input  logic                  re2,
  input  logic [SCB_ADDR_W-1:0] raddr2,
  input  logic                  wb_we,
  input  logic [SCB_ADDR_W-1:0] wb_waddr,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  issue_fire,
  output logic [REG_NUM-1:0]    busy,
  output logic                  err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   cnt [REG_NUM];
  logic [REG_NUM-1:0] zero;
  logic [REG_NUM-1:0] inc;
  logic [REG_NUM-1:0] dec;

  logic [CNT_W-1:0] cnt_r1, cnt_r2, cnt_w, cnt_wb;
  logic             hazard1, hazard2, overflow, err_set;

  // A source is pending if writes remain after counting a same-cycle retire
  // as done. Written as a compare rather than a subtraction so that a bogus
  // retire on an idle register cannot underflow into a false hazard.
  function automatic logic pending(input logic [CNT_W-1:0] c, input logic retire);
    return (c != '0) && !(retire && (c == CNT_W'(1)));
  endfunction

  assign cnt_r1 = cnt[raddr1];
  assign cnt_r2 = cnt[raddr2];
  assign cnt_w  = cnt[issue_waddr];
  assign cnt_wb = cnt[wb_waddr];

  assign hazard1  = re1 && (raddr1 != '0) && pending(cnt_r1, wr_hit(wb_we, wb_waddr, raddr1));
  assign hazard2  = re2 && (raddr2 != '0) && pending(cnt_r2, wr_hit(wb_we, wb_waddr, raddr2));
  assign overflow = issue_we && (issue_waddr != '0) && (cnt_w == CNT_MAX) &&
                    !wr_hit(wb_we, wb_waddr, issue_waddr);

  // Counters are already clear under reset; the explicit gate keeps the
  // request quiet even while reset is being applied asynchronously.
  assign stall_req  = (rst == RSTN_DISABLE) && issue_valid && !flush &&
                      (hazard1 || hazard2 || overflow);
  assign issue_fire = issue_valid && !stall_req && !flush;

  assign err_set = wb_we && (wb_waddr != '0) && (cnt_wb == '0) && !flush;

  genvar n;
  generate
    for (n = 0; n < REG_NUM; n++) begin : g_reg
      if (n == 0) begin : g_zero
        assign cnt[n]  = '0;
        assign zero[n] = 1'b1;
        assign inc[n]  = 1'b0;
        assign dec[n]  = 1'b0;
      end else begin : g_cnt
        assign inc[n] = issue_fire && issue_we && (issue_waddr == SCB_ADDR_W'(n));
        assign dec[n] = wb_we && (wb_waddr == SCB_ADDR_W'(n)) && !zero[n];

        scb_cnt #(.CNT_W(CNT_W)) u_cnt (
          .clk  (clk),
          .rst  (rst),
          .clr  (flush),
          .inc  (inc[n]),
          .dec  (dec[n]),
          .cnt  (cnt[n]),
          .zero (zero[n])
        );
      end
      assign busy[n] = !zero[n];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_waddr;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic        flush;
  logic        stall_req, issue_fire;
  logic [31:0] busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  int          mcnt [32];
  bit          merr;
  logic [31:0] exp_q [$];

  reg_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_waddr (issue_waddr),
    .re1         (re1),
    .raddr1      (raddr1),
    .re2         (re2),
    .raddr2      (raddr2),
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .flush       (flush),
    .stall_req   (stall_req),
    .issue_fire  (issue_fire),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit m_pend(input int a);
    int e;
    e = mcnt[a] - ((wb_we && wb_waddr == a) ? 1 : 0);
    return e > 0;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int i = 1; i < 32; i++) b[i] = (mcnt[i] != 0);
    return b;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    merr = 0;
  endtask

  // One clock: drive at negedge, check combinational outputs, then check
  // registered outputs just after the rising edge.
  task automatic step(input bit v, input bit we, input int wa,
                      input bit r1, input int a1, input bit r2, input int a2,
                      input bit wbe, input int wba, input bit fl);
    bit h1, h2, ov, es, ef, inc, dec;
    @(negedge clk);
    issue_valid = v;   issue_we = we;  issue_waddr = 5'(wa);
    re1 = r1;          raddr1 = 5'(a1);
    re2 = r2;          raddr2 = 5'(a2);
    wb_we = wbe;       wb_waddr = 5'(wba);
    flush = fl;
    #1;
    h1 = r1 && a1 != 0 && m_pend(a1);
    h2 = r2 && a2 != 0 && m_pend(a2);
    ov = we && wa != 0 && mcnt[wa] == 3 && !(wbe && wba == wa);
    es = v && !fl && (h1 || h2 || ov);
    ef = v && !es && !fl;
    exp_q.push_back(32'(es));
    exp_q.push_back(32'(ef));
    chk("stall_req", 32'(stall_req), exp_q.pop_front());
    chk("issue_fire", 32'(issue_fire), exp_q.pop_front());
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      if (wbe && wba != 0 && mcnt[wba] == 0) merr = 1;
      for (int i = 1; i < 32; i++) begin
        inc = ef && we && wa == i;
        dec = wbe && wba == i && mcnt[i] != 0;
        if (inc && !dec) mcnt[i]++;
        else if (dec && !inc) mcnt[i]--;
      end
    end
    #1;
    exp_q.push_back(m_busy());
    exp_q.push_back(32'(merr));
    chk("busy", busy, exp_q.pop_front());
    chk("err", 32'(err), exp_q.pop_front());
  endtask

  initial begin
    issue_valid = 0; issue_we = 0; issue_waddr = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    wb_we = 0; wb_waddr = 0; flush = 0;
    rst = 0;
    m_clear();
    #12;
    chk("reset_busy", busy, 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_stall", 32'(stall_req), 32'h0);
    @(negedge clk);
    rst = 1;

    // RAW on $5, unblocked by a same-cycle retire
    step(1,1,5, 0,0,0,0, 0,0, 0);
    chk("busy5_set", 32'(busy[5]), 32'h1);
    step(1,0,0, 1,5,0,0, 0,0, 0);
    chk("raw5_stall", 32'(stall_req), 32'h1);
    step(1,0,0, 1,5,0,0, 1,5, 0);
    chk("raw5_bypass", 32'(stall_req), 32'h0);
    chk("busy5_clr", 32'(busy[5]), 32'h0);

    // saturation on $7
    step(1,1,7, 0,0,0,0, 0,0, 0);
    step(1,1,7, 0,0,0,0, 0,0, 0);
    step(1,1,7, 0,0,0,0, 0,0, 0);
    step(1,1,7, 0,0,0,0, 0,0, 0);
    chk("ovf7_fire", 32'(issue_fire), 32'h0);
    step(1,1,7, 0,0,0,0, 1,7, 0);
    chk("ovf7_retire_fire", 32'(issue_fire), 32'h1);
    step(1,1,7, 0,0,0,0, 0,0, 0);
    chk("ovf7_still_full", 32'(stall_req), 32'h1);
    step(0,0,0, 0,0,0,0, 0,0, 1);

    // register 0 is never tracked
    step(1,1,0, 1,0,1,0, 0,0, 0);
    step(1,0,0, 1,0,0,0, 1,0, 0);
    chk("r0_busy", busy, 32'h0);
    chk("r0_err", 32'(err), 32'h0);

    // self-dependency: addu $3,$3,$4 issues, a second reads the older $3
    step(1,1,3, 1,3,1,4, 0,0, 0);
    step(1,1,3, 1,3,1,4, 0,0, 0);
    chk("selfdep_stall", 32'(stall_req), 32'h1);

    // flush with a concurrent retire
    step(1,1,9, 0,0,0,0, 0,0, 0);
    step(1,1,10, 0,0,0,0, 0,0, 0);
    step(1,1,11, 1,9,0,0, 1,9, 1);
    chk("flush_busy", busy, 32'h0);
    chk("flush_err", 32'(err), 32'h0);

    // retire of an idle register latches err
    step(0,0,0, 0,0,0,0, 1,12, 0);
    chk("err_set", 32'(err), 32'h1);
    step(0,0,0, 0,0,0,0, 0,0, 0);
    step(0,0,0, 0,0,0,0, 0,0, 1);
    chk("err_sticky", 32'(err), 32'h1);

    // random traffic on a small address window
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,7),
           $urandom_range(0,1), $urandom_range(0,7),
           $urandom_range(0,1), $urandom_range(0,7),
           $urandom_range(0,1), $urandom_range(0,7),
           ($urandom_range(0,24) == 0));
    end

    // asynchronous reset in mid-cycle with registers busy
    step(0,0,0, 0,0,0,0, 0,0, 1);
    step(1,1,6, 0,0,0,0, 0,0, 0);
    step(1,1,8, 0,0,0,0, 1,13, 0);
    chk("pre_rst_busy", busy, 32'h0000_0140);
    @(negedge clk);
    issue_valid = 1; issue_we = 0; re1 = 1; raddr1 = 6; wb_we = 0; flush = 0;
    #1;
    chk("pre_rst_stall", 32'(stall_req), 32'h1);
    rst = 0;
    #1;
    chk("async_busy", busy, 32'h0);
    chk("async_err", 32'(err), 32'h0);
    chk("async_stall", 32'(stall_req), 32'h0);
    m_clear();
    @(negedge clk);
    rst = 1;
    step(1,0,0, 1,6,1,8, 0,0, 0);
    chk("post_rst_stall", 32'(stall_req), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
